div_unit: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
Sits in the EX stage beside the ALU adder. It consumes the same 32-bit operands, subtracts once per cycle and uses the borrow result to pick each quotient bit.
The pipeline stalls while busy=1 and takes result when done=1.

---
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional early-exit path for special cases and |opA|<|opB| enabled by DIV_FAST_EN.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] opa_q;
  logic             is_rem;
  logic             sign_q;
  logic             sign_r;
  logic             div0;
  logic             ovf;

  logic             sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             cap_div0;
  logic             cap_ovf;
  logic [WIDTH:0]   t_upper;
  logic [WIDTH+1:0] sub;
  logic             borrow;
  logic             unused_sub_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fix_val;

  always_comb begin
    sgn      = ~op[0];
    abs_a    = (sgn && opA[WIDTH-1]) ? -opA : opA;
    abs_b    = (sgn && opB[WIDTH-1]) ? -opB : opB;
    cap_div0 = (opB == '0);
    cap_ovf  = sgn && (opA == MIN_VAL) && (opB == '1);
  end

  // The shifted partial remainder needs WIDTH+1 bits; the extra sub bit is the borrow.
  always_comb begin
    t_upper        = {rem, dvd[WIDTH-1]};
    sub            = {1'b0, t_upper} - {2'b00, dvs};
    borrow         = sub[WIDTH+1];
    unused_sub_bit = sub[WIDTH];
  end

  always_comb begin
    q_fix = sign_q ? -dvd : dvd;
    r_fix = sign_r ? -rem : rem;
    if (div0) begin
      q_fix = '1;
      r_fix = opa_q;
    end else if (ovf) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
    fix_val = is_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      opa_q   <= '0;
      is_rem  <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_rem  <= op[1];
            dvs     <= abs_b;
            opa_q   <= opA;
            sign_q  <= sgn && (opA[WIDTH-1] ^ opB[WIDTH-1]);
            sign_r  <= sgn && opA[WIDTH-1];
            div0    <= cap_div0;
            ovf     <= cap_ovf;
            counter <= CW'(WIDTH);
            busy    <= 1'b1;
`ifdef DIV_FAST_EN
            if (cap_div0 || cap_ovf || (abs_a < abs_b)) begin
              dvd   <= '0;
              rem   <= abs_a;
              state <= FIX;
            end else begin
              dvd   <= abs_a;
              rem   <= '0;
              state <= RUN;
            end
`else
            dvd   <= abs_a;
            rem   <= '0;
            state <= RUN;
`endif
          end
        end
        RUN: begin
          rem     <= borrow ? t_upper[WIDTH-1:0] : sub[WIDTH-1:0];
          dvd     <= {dvd[WIDTH-2:0], ~borrow};
          counter <= counter - CW'(1);
          if (counter == CW'(1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops vs. arithmetic model,
// and hand-written flush / busy-start / async-reset sequences.
module tb_div_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [1:0]   op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  // Edges counted from the start-sampling edge (inclusive) until done is visible.
  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    bit fast_en;
    bit special;
`ifdef DIV_FAST_EN
    fast_en = 1'b1;
`else
    fast_en = 1'b0;
`endif
    ma = (!o[0] && a[W-1]) ? -a : a;
    mb = (!o[0] && b[W-1]) ? -b : b;
    special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
    if (fast_en && special) return 2;
    return W + 2;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_bad++;
      @(posedge clk);
      lat++;
    end
    if (!done) lat = -1;
    res = result;
    check("busy_during_op", busy_bad, 0);
    @(posedge clk);
    #1;
    check("done_single_pulse", {31'b0, done}, 0);
    check("busy_after_done", {31'b0, busy}, 0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl[13];
  logic [W-1:0] res;
  logic [W-1:0] last_exp;
  int           lat;
  int           seen;
  logic [1:0]   ro;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    tbl[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    tbl[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    tbl[2]  = '{2'b11, 32'd100,       32'd7,          32'd2};
    tbl[3]  = '{2'b01, 32'd100,       32'd7,          32'h0000_000E};
    tbl[4]  = '{2'b01, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF};
    tbl[5]  = '{2'b10, 32'h1234_5678, 32'd0,          32'h1234_5678};
    tbl[6]  = '{2'b00, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF};
    tbl[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000};
    tbl[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0};
    tbl[9]  = '{2'b01, 32'd9,         32'd3,          32'd3};
    tbl[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,          32'd0};
    tbl[11] = '{2'b00, 32'd5,         32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[12] = '{2'b10, 32'd5,         32'hFFFF_FFFD,  32'd2};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), lat, model_lat(tbl[i].op, tbl[i].a, tbl[i].b));
      last_exp = tbl[i].exp;
    end

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 40); end
        3: rb = -($urandom_range(1, 100));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, res, lat);
      last_exp = model(ro, ra, rb);
      check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, ro, ra, rb), res, last_exp);
      check($sformatf("rand%0d_latency", i), lat, model_lat(ro, ra, rb));
    end

    // Flush during RUN: abort, no done, result held, then a fresh op.
    @(negedge clk);
    start = 1'b1; op = 2'b01; opA = 32'd100; opB = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 0);
    check("flush_done", {31'b0, done}, 0);
    check("flush_result_held", result, last_exp);
    run_op(2'b01, 32'd9, 32'd3, res, lat);
    check("after_flush_result", res, 32'd3);
    check("after_flush_latency", lat, model_lat(2'b01, 32'd9, 32'd3));

    // Flush and start together in IDLE: nothing launches.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; opA = 32'd100; opB = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("flush_start_idle_busy", {31'b0, busy}, 0);

    // Start while busy is ignored and not queued.
    @(negedge clk);
    start = 1'b1; op = 2'b01; opA = 32'd100; opB = 32'd7;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    seen = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (done) break;
      if (lat == 5) begin
        start = 1'b1; op = 2'b01; opA = 32'd9; opB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) lat = -1;
    check("busy_start_result", result, 32'h0000_000E);
    check("busy_start_latency", lat, W + 2);
    repeat (4) @(negedge clk) if (busy || done) seen++;
    check("busy_start_not_queued", seen, 0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1; op = 2'b00; opA = 32'hFFFF_FFF9; opB = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 0);
    check("async_rst_done", {31'b0, done}, 0);
    check("async_rst_result", result, 0);
    @(negedge clk) rst = 1'b0;
    run_op(2'b01, 32'd100, 32'd7, res, lat);
    check("after_rst_result", res, 32'h0000_000E);
    check("after_rst_latency", lat, W + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
